// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch constants and FSM encoding
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, imem and IF/ID signal bundle
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        go;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, halt, go, imem_rdata,
        output imem_addr, ir, id_pc4, id_valid, halted, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, halt, go, imem_rdata,
        input  imem_addr, ir, id_pc4, id_valid, halted, fetch_count
    );
endinterface

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter with sequential/redirect next-PC select
module pc_register
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (!hold) begin
            pc <= redirect ? word_align(redirect_pc) : pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, IF/ID register, RUN/HALTED FSM, fetch counter
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    fetch_state_t state_q, state_d;
    logic         pc_hold;
    logic         pc_redirect;
    logic         load_valid;
    logic         load_bubble;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  ir_q;
    logic [31:0]  id_pc4_q;
    logic         id_valid_q;
    logic         halted_q;
    logic [31:0]  fetch_count_q;

    pc_register u_pc_register (
        .clk         (clk),
        .rst         (rst),
        .hold        (pc_hold),
        .redirect    (pc_redirect),
        .redirect_pc (bus.redirect_pc),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    // Stall outranks halt, halt outranks redirect; HALTED ignores everything but go.
    always_comb begin
        state_d     = state_q;
        pc_hold     = 1'b1;
        pc_redirect = 1'b0;
        load_valid  = 1'b0;
        load_bubble = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!bus.stall) begin
                    if (bus.halt) begin
                        state_d     = ST_HALTED;
                        load_bubble = 1'b1;
                    end else if (bus.redirect) begin
                        pc_hold     = 1'b0;
                        pc_redirect = 1'b1;
                        load_bubble = 1'b1;
                    end else begin
                        pc_hold    = 1'b0;
                        load_valid = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (bus.go) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q          <= NOP_WORD;
            id_pc4_q      <= 32'd0;
            id_valid_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else if (load_valid) begin
            ir_q          <= bus.imem_rdata;
            id_pc4_q      <= pc_plus4;
            id_valid_q    <= 1'b1;
            fetch_count_q <= fetch_count_q + 32'd1;
        end else if (load_bubble) begin
            ir_q       <= NOP_WORD;
            id_valid_q <= 1'b0;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.ir          = ir_q;
    assign bus.id_pc4      = id_pc4_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'd0;
        bus.halt = 1'b0; bus.go = 1'b0;
        #12;
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", bus.imem_addr, 32'h0); end
        checks++; if (bus.ir !== 32'h0) begin errors++; $display("FAIL reset_ir got %h want %h", bus.ir, 32'h0); end
        checks++; if (bus.id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h want %h", bus.id_pc4, 32'h0); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.id_valid); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.halted); end
        checks++; if (bus.fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.fetch_count); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_ir [3];
        exp_ir[0] = 32'hA5A5_0000; exp_ir[1] = 32'hA5A5_0004; exp_ir[2] = 32'hA5A5_0008;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.ir !== exp_ir[k]) begin errors++; $display("FAIL seq_ir%0d got %h want %h", k, bus.ir, exp_ir[k]); end
            checks++; if (bus.id_pc4 !== 32'(4 * (k + 1))) begin errors++; $display("FAIL seq_pc4%0d got %h want %h", k, bus.id_pc4, 4 * (k + 1)); end
            checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d got %b want 1", k, bus.id_valid); end
        end
        checks++; if (bus.fetch_count !== 32'd3) begin errors++; $display("FAIL seq_count got %0d want 3", bus.fetch_count); end
        checks++; if (bus.imem_addr !== 32'hC) begin errors++; $display("FAIL seq_addr got %h want %h", bus.imem_addr, 32'hC); end
    endtask

    task automatic test_redirect();
        step();
        checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL redir_pre_addr got %h want %h", bus.imem_addr, 32'h10); end
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %h want %h", bus.imem_addr, 32'h100); end
        checks++; if (bus.ir !== 32'h0) begin errors++; $display("FAIL redir_ir got %h want %h", bus.ir, 32'h0); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", bus.id_valid); end
        checks++; if (bus.fetch_count !== 32'd4) begin errors++; $display("FAIL redir_count got %0d want 4", bus.fetch_count); end
        step();
        checks++; if (bus.ir !== 32'hA5A5_0100) begin errors++; $display("FAIL redir_target_ir got %h want %h", bus.ir, 32'hA5A5_0100); end
        checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL redir_target_valid got %b want 1", bus.id_valid); end
        checks++; if (bus.fetch_count !== 32'd5) begin errors++; $display("FAIL redir_target_count got %0d want 5", bus.fetch_count); end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200; bus.halt = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (bus.imem_addr !== 32'h104) begin errors++; $display("FAIL stall_addr%0d got %h want %h", k, bus.imem_addr, 32'h104); end
            checks++; if (bus.ir !== 32'hA5A5_0100) begin errors++; $display("FAIL stall_ir%0d got %h want %h", k, bus.ir, 32'hA5A5_0100); end
            checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got %b want 1", k, bus.id_valid); end
            checks++; if (bus.fetch_count !== 32'd5) begin errors++; $display("FAIL stall_count%0d got %0d want 5", k, bus.fetch_count); end
            checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL stall_halted%0d got %b want 0", k, bus.halted); end
        end
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.halt = 1'b0;
        step();
        checks++; if (bus.ir !== 32'hA5A5_0104) begin errors++; $display("FAIL stall_release_ir got %h want %h", bus.ir, 32'hA5A5_0104); end
        checks++; if (bus.fetch_count !== 32'd6) begin errors++; $display("FAIL stall_release_count got %0d want 6", bus.fetch_count); end
    endtask

    task automatic test_halt();
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0020;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("FAIL halt_pre_addr got %h want %h", bus.imem_addr, 32'h20); end
        bus.halt = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0300;
        step();
        bus.halt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_flag%0d got %b want 1", k, bus.halted); end
            checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("FAIL halt_addr%0d got %h want %h", k, bus.imem_addr, 32'h20); end
            checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL halt_valid%0d got %b want 0", k, bus.id_valid); end
            step();
        end
        checks++; if (bus.fetch_count !== 32'd6) begin errors++; $display("FAIL halt_count got %0d want 6", bus.fetch_count); end
        bus.redirect = 1'b0; bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL go_halted got %b want 0", bus.halted); end
        step();
        checks++; if (bus.ir !== 32'hA5A5_0020) begin errors++; $display("FAIL go_ir got %h want %h", bus.ir, 32'hA5A5_0020); end
        checks++; if (bus.fetch_count !== 32'd7) begin errors++; $display("FAIL go_count got %0d want 7", bus.fetch_count); end
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        checks++; if (bus.ir !== 32'hA5A5_0024) begin errors++; $display("FAIL go_in_run_ir got %h want %h", bus.ir, 32'hA5A5_0024); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL go_in_run_halted got %b want 0", bus.halted); end
    endtask

    task automatic test_wrap();
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_addr got %h want %h", bus.imem_addr, 32'hFFFF_FFFC); end
        step();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want %h", bus.imem_addr, 32'h0); end
        checks++; if (bus.ir !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_ir got %h want %h", bus.ir, 32'h5A5A_FFFC); end
        checks++; if (bus.id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want %h", bus.id_pc4, 32'h0); end
        checks++; if (bus.fetch_count !== 32'd9) begin errors++; $display("FAIL wrap_count got %0d want 9", bus.fetch_count); end
    endtask

    task automatic test_async_reset_halted();
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL ares_pre_halted got %b want 1", bus.halted); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL ares_halted got %b want 0", bus.halted); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL ares_addr got %h want %h", bus.imem_addr, 32'h0); end
        checks++; if (bus.fetch_count !== 32'd0) begin errors++; $display("FAIL ares_count got %0d want 0", bus.fetch_count); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL ares_valid got %b want 0", bus.id_valid); end
        step();
        rst = 1'b0;
        step();
        checks++; if (bus.ir !== 32'hA5A5_0000) begin errors++; $display("FAIL ares_first_ir got %h want %h", bus.ir, 32'hA5A5_0000); end
        checks++; if (bus.fetch_count !== 32'd1) begin errors++; $display("FAIL ares_first_count got %0d want 1", bus.fetch_count); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_halt();
        test_wrap();
        test_async_reset_halted();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 RESET_PC, 32'h0000_0000: byte address loaded into PC on reset.
REQ-002 NOP_WORD, 32'h0000_0000: instruction word injected as a bubble.
REQ-003 The module SHALL have a single clock and an asynchronous active-high reset.
REQ-004 The ports SHALL be:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- stall, input, 1: hold PC and the IF/ID register (load-use hazard from ID).
- redirect, input, 1: taken branch or jump resolved in ID.
- redirect_pc, input, 32: target byte address.
- halt, input, 1: syscall halt request from ID.
- go, input, 1: resume pulse while halted.
- imem_addr, output, 32: current PC, drives the combinational instruction memory.
- imem_rdata, input, 32: instruction at imem_addr, same cycle.
- ir, output, 32: IF/ID instruction, feeds the decode/control stage.
- id_pc4, output, 32: PC+4 of the instruction in ir.
- id_valid, output, 1: ir holds a real instruction, not a bubble.
- halted, output, 1: fetch is frozen.
- fetch_count, output, 32: count of valid instructions delivered to ID.

Function
REQ-005 The state machine SHALL have two states, RUN and HALTED, and SHALL enter RUN on reset.
REQ-006 imem_addr SHALL equal the PC register; PC[1:0] SHALL always be 2'b00.
REQ-007 In RUN with stall=0, redirect=0 and halt=0, each clock edge SHALL do the following:
- PC <= PC+4, mod 2^32 (0xFFFF_FFFC wraps to 0).
- ir <= imem_rdata; id_pc4 <= PC+4; id_valid <= 1.
REQ-008 Latency: an instruction SHALL appear on ir exactly one cycle after its address is on imem_addr.
REQ-009 In RUN with stall=0 and redirect=1, the block SHALL do the following:
- PC <= {redirect_pc[31:2],2'b00}.
- ir <= NOP_WORD, id_valid <= 0 (wrong-path squash; there is no delay slot).
REQ-010 With stall=1, PC, ir, id_pc4 and id_valid SHALL hold, and redirect and halt SHALL be ignored that cycle.
REQ-011 In RUN with stall=0 and halt=1, the block SHALL do the following:
- Go to HALTED.
- Hold PC.
- ir <= NOP_WORD, id_valid <= 0.
- halt SHALL take priority over redirect.
REQ-012 In HALTED, the block SHALL do the following:
- PC holds; ir stays NOP_WORD with id_valid=0.
- halted=1.
- stall, redirect and halt are ignored.
REQ-013 In HALTED with go=1, the block SHALL return to RUN next cycle and resume fetching at the held PC.
REQ-014 go SHALL be ignored in RUN.
REQ-015 fetch_count SHALL increment by 1 (wrapping) on every edge where id_valid is loaded with 1.
REQ-016 fetch_count SHALL NOT increment on bubble loads or hold cycles.
REQ-017 Priority, highest first: rst, stall, halt, redirect, sequential.
REQ-018 halted SHALL be a registered decode of the state.

Reset
REQ-019 On rst=1, asynchronously and without waiting for a clock edge, the block SHALL set:
- PC=RESET_PC.
- ir=NOP_WORD, id_pc4=0, id_valid=0.
- fetch_count=0.
- state=RUN, halted=0.
REQ-020 Reset asserted mid-stall or in HALTED SHALL override everything.
REQ-021 After rst deasserts, the first edge SHALL load the instruction at RESET_PC into ir.

Structure
REQ-022 A shared package SHALL hold RESET_PC, NOP_WORD and the RUN/HALTED state encoding, so the control and hazard units can use them too.
REQ-023 The PC register with next-PC selection SHALL be one sub-module, pc_register. The IF/ID register, FSM and counter SHALL stay in fetch_stage.

Verification
REQ-024 Reset then 3 free cycles, with imem returning addr^32'hA5A5_0000 -> ir sequence 0xA5A50000, 0xA5A50004, 0xA5A50008; id_pc4 = 4, 8, 0xC; fetch_count=3.
REQ-025 redirect=1, redirect_pc=0x0000_0103 at PC=0x10 -> next imem_addr=0x100; ir=0 with id_valid=0 for one cycle; fetch_count unchanged.
REQ-026 stall=1 for 2 cycles with redirect=1 and halt=1 asserted concurrently -> PC, ir and fetch_count are all frozen; no redirect; halted stays 0.
REQ-027 halt=1 at PC=0x20 -> halted=1 and imem_addr stays 0x20 for 5 cycles; a go pulse -> the next ir is the word at 0x20.
REQ-028 PC forced to 0xFFFF_FFFC via redirect -> the following imem_addr is 0x0000_0000.
REQ-029 rst asserted asynchronously mid-cycle while HALTED -> outputs reach reset values before the next edge.
